// File: rtl/encoder_8to3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : enc_pkg
// Description : Shared sizes, FSM state type and popcount helper for the
//               sequential 8-to-3 encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int N  = 8;
    localparam int CW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    function automatic logic [CW:0] popcount(input logic [N-1:0] v);
        logic [CW:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{CW{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_8to3_ctrl_pick_first.sv
`default_nettype none
// ============================================================================
// Module      : pick_first
// Description : Combinational search for the first set request at or above a
//               start index, wrapping modulo N.
// Ports       : i_req   - request vector
//               i_start - index where the search begins
//               o_found - at least one request is set
//               o_idx   - index of the first set request found
// Revision    : 1.0 - initial release
// ============================================================================
module pick_first #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_start,
    output logic          o_found,
    output logic [CW-1:0] o_idx
);
    import enc_pkg::*;

    logic [N-1:0]  w_rot;
    logic [CW-1:0] w_pos;

    // Rotate so the start index lands at bit 0, take the lowest set bit, then
    // add the start back. CW-bit arithmetic wraps naturally because N = 2**CW.
    always_comb begin
        w_rot = '0;
        w_pos = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = i_req[CW'(j) + i_start];
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_pos = CW'(j);
            end
        end
        o_found = |i_req;
        o_idx   = w_pos + i_start;
    end

endmodule
`default_nettype wire

// File: rtl/encoder_8to3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8to3_ctrl
// Description : Captures rising edges on N request lines into pending bits and
//               presents one pending index at a time as a CW-bit code with a
//               valid/ready handshake. Lost edges raise a sticky overflow.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               i_en        - edge capture enable (pending still drains)
//               i_y_in      - request lines
//               i_ready     - consumer accepts the code this cycle
//               i_clr_ovf   - synchronous overflow clear
//               o_code      - granted index
//               o_valid     - o_code is valid
//               o_pending   - pending vector
//               o_pend_cnt  - popcount of pending
//               o_overflow  - sticky lost-edge flag
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8to3_ctrl #(
    parameter int N           = 8,
    parameter int CW          = 3,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [N-1:0]  i_y_in,
    input  logic          i_ready,
    input  logic          i_clr_ovf,
    output logic [CW-1:0] o_code,
    output logic          o_valid,
    output logic [N-1:0]  o_pending,
    output logic [CW:0]   o_pend_cnt,
    output logic          o_overflow
);
    import enc_pkg::*;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_y_prev;
    logic [N-1:0]  r_pending;
    logic [CW:0]   r_pend_cnt;
    logic [CW-1:0] r_code;
    logic          r_overflow;

    logic [N-1:0]  w_edge;
    logic [N-1:0]  w_grant_clr;
    logic [N-1:0]  w_pending_nxt;
    logic          w_found;
    logic [CW-1:0] w_pick;
    logic          w_load;

    // Picks always look at the registered pending vector, so an edge arriving
    // this cycle only becomes eligible next cycle.
    generate
        if (ROUND_ROBIN) begin : g_rr
            logic [CW-1:0] r_rr_ptr;

            pick_first #(.N(N), .CW(CW)) u_pick (
                .i_req   (r_pending),
                .i_start (r_rr_ptr + 1'b1),
                .o_found (w_found),
                .o_idx   (w_pick)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rr_ptr <= CW'(N - 1);
                end else if (w_load) begin
                    r_rr_ptr <= w_pick;
                end
            end
        end else begin : g_fp
            logic [N-1:0]  w_rev;
            logic [CW-1:0] w_rev_idx;

            // Highest index first: reverse the vector, find the lowest set
            // bit from 0, and mirror the index back.
            always_comb begin
                w_rev = '0;
                for (int j = 0; j < N; j++) begin
                    w_rev[j] = r_pending[N - 1 - j];
                end
            end

            pick_first #(.N(N), .CW(CW)) u_pick (
                .i_req   (w_rev),
                .i_start ('0),
                .o_found (w_found),
                .o_idx   (w_rev_idx)
            );

            assign w_pick = CW'(N - 1) - w_rev_idx;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = VALID;
                end
            end
            VALID: begin
                if (i_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_edge      = i_y_in & ~r_y_prev & {N{i_en}};
        w_grant_clr = '0;
        if (w_load) begin
            w_grant_clr[w_pick] = 1'b1;
        end
        // A fresh edge on the bit being granted re-arms it as a new event.
        w_pending_nxt = (r_pending & ~w_grant_clr) | w_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_y_prev   <= '0;
            r_pending  <= '0;
            r_pend_cnt <= '0;
            r_code     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_y_prev   <= i_y_in;
            r_pending  <= w_pending_nxt;
            r_pend_cnt <= popcount(w_pending_nxt);
            if (w_load) begin
                r_code <= w_pick;
            end
            // Set has priority over a simultaneous clear.
            if (|(w_edge & r_pending & ~w_grant_clr)) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_code     = r_code;
    assign o_valid    = (r_state == VALID);
    assign o_pending  = r_pending;
    assign o_pend_cnt = r_pend_cnt;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_encoder_8to3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_8to3_ctrl
// Description : Directed self-checking bench for encoder_8to3_ctrl, with one
//               fixed-priority and one round-robin instance on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_8to3_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] y_in;
    logic       ready;
    logic       clr_ovf;

    logic [2:0] fp_code,   rr_code;
    logic       fp_valid,  rr_valid;
    logic [7:0] fp_pend,   rr_pend;
    logic [3:0] fp_cnt,    rr_cnt;
    logic       fp_ovf,    rr_ovf;

    int checks   = 0;
    int failures = 0;

    encoder_8to3_ctrl #(.N(8), .CW(3), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_y_in     (y_in),
        .i_ready    (ready),
        .i_clr_ovf  (clr_ovf),
        .o_code     (fp_code),
        .o_valid    (fp_valid),
        .o_pending  (fp_pend),
        .o_pend_cnt (fp_cnt),
        .o_overflow (fp_ovf)
    );

    encoder_8to3_ctrl #(.N(8), .CW(3), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_y_in     (y_in),
        .i_ready    (ready),
        .i_clr_ovf  (clr_ovf),
        .o_code     (rr_code),
        .o_valid    (rr_valid),
        .o_pending  (rr_pend),
        .o_pend_cnt (rr_cnt),
        .o_overflow (rr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        y_in    = 8'h00;
        ready   = 1'b0;
        clr_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        y_in    = 8'h00;
        ready   = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        check("rst_code",    32'(fp_code),  32'd0);
        check("rst_valid",   32'(fp_valid), 32'd0);
        check("rst_pending", 32'(fp_pend),  32'h00);
        check("rst_cnt",     32'(fp_cnt),   32'd0);
        check("rst_ovf",     32'(fp_ovf),   32'd0);
        check("rst_rr_valid", 32'(rr_valid), 32'd0);
        rst_n = 1'b1;

        // Single line 2: two-edge latency, then drains
        en = 1'b1; ready = 1'b1; y_in = 8'h04;
        tick();
        check("l2_pending", 32'(fp_pend),  32'h04);
        check("l2_cnt1",    32'(fp_cnt),   32'd1);
        check("l2_valid0",  32'(fp_valid), 32'd0);
        tick();
        check("l2_valid1",  32'(fp_valid), 32'd1);
        check("l2_code",    32'(fp_code),  32'd2);
        check("l2_cnt0",    32'(fp_cnt),   32'd0);
        tick();
        check("l2_drop",    32'(fp_valid), 32'd0);
        check("l2_hold",    32'(fp_code),  32'd2);
        y_in = 8'h00;
        tick();

        // Fixed priority 0x91 -> 7,4,0
        y_in = 8'h91;
        tick();
        check("fp_pending", 32'(fp_pend), 32'h91);
        check("fp_cnt3",    32'(fp_cnt),  32'd3);
        y_in = 8'h00;
        tick();
        check("fp_code7",  32'(fp_code),  32'd7);
        check("fp_valid7", 32'(fp_valid), 32'd1);
        check("fp_cnt2",   32'(fp_cnt),   32'd2);
        tick();
        check("fp_code4",  32'(fp_code),  32'd4);
        check("fp_cnt1",   32'(fp_cnt),   32'd1);
        tick();
        check("fp_code0",  32'(fp_code),  32'd0);
        check("fp_valid0_still", 32'(fp_valid), 32'd1);
        check("fp_cnt0",   32'(fp_cnt),   32'd0);
        tick();
        check("fp_idle",   32'(fp_valid), 32'd0);

        // Mid-stream asynchronous reset
        ready = 1'b0; y_in = 8'h01;
        tick();
        y_in = 8'h00;
        tick();
        y_in = 8'hA5;
        tick();
        check("mr_pending_pre", 32'(fp_pend),  32'hA5);
        check("mr_valid_pre",   32'(fp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_pending", 32'(fp_pend),  32'h00);
        check("mr_valid",   32'(fp_valid), 32'd0);
        check("mr_cnt",     32'(fp_cnt),   32'd0);
        check("mr_code",    32'(fp_code),  32'd0);
        check("mr_ovf",     32'(fp_ovf),   32'd0);
        y_in = 8'h00;
        tick();
        rst_n = 1'b1;

        // Round robin alternation on repeated 0x81 edges
        en = 1'b1; ready = 1'b1; y_in = 8'h81;
        tick();
        check("rr_pending", 32'(rr_pend), 32'h81);
        y_in = 8'h00;
        tick();
        check("rr_code_a", 32'(rr_code), 32'd0);
        check("rr_valid",  32'(rr_valid), 32'd1);
        y_in = 8'h81;
        tick();
        check("rr_code_b", 32'(rr_code), 32'd7);
        y_in = 8'h00;
        tick();
        check("rr_code_c", 32'(rr_code), 32'd0);
        y_in = 8'h81;
        tick();
        check("rr_code_d", 32'(rr_code), 32'd7);
        check("rr_no_ovf", 32'(rr_ovf),  32'd0);
        do_reset();

        // Backpressure and overflow
        en = 1'b1; ready = 1'b0; y_in = 8'h08;
        tick();
        y_in = 8'h00;
        tick();
        check("bp_code",  32'(fp_code),  32'd3);
        check("bp_valid", 32'(fp_valid), 32'd1);
        y_in = 8'h08;
        tick();
        check("bp_repend", 32'(fp_pend), 32'h08);
        check("bp_ovf0",   32'(fp_ovf),  32'd0);
        y_in = 8'h00;
        tick();
        y_in = 8'h08;
        tick();
        check("bp_ovf1",      32'(fp_ovf),   32'd1);
        check("bp_code_hold", 32'(fp_code),  32'd3);
        check("bp_valid_hold", 32'(fp_valid), 32'd1);
        y_in = 8'h00; clr_ovf = 1'b1;
        tick();
        check("bp_clr", 32'(fp_ovf), 32'd0);
        y_in = 8'h08;
        tick();
        check("bp_set_wins", 32'(fp_ovf), 32'd1);
        clr_ovf = 1'b0;
        do_reset();

        // Enable gating
        en = 1'b0; y_in = 8'h10;
        tick();
        check("en0_pending", 32'(fp_pend), 32'h00);
        en = 1'b1;
        tick();
        check("en_rise_pending", 32'(fp_pend), 32'h00);
        tick();
        check("en_rise_valid", 32'(fp_valid), 32'd0);
        y_in = 8'h00;
        tick();
        y_in = 8'h10;
        tick();
        check("en_edge_pending", 32'(fp_pend), 32'h10);
        tick();
        check("en_edge_code",  32'(fp_code),  32'd4);
        check("en_edge_valid", 32'(fp_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encoder_8to3_ctrl.md
Name: encoder_8to3_ctrl

Overview:
Sequential 8-to-3 encoder: the inverse path of the team's 3-to-8 decoder. It captures rising edges on eight request lines Y[7:0] into pending bits, then presents one pending index at a time as a 3-bit code with a valid/ready handshake. It sits in front of any consumer that needs decoded line activity turned back into a binary index, such as interrupt or event collection.

Parameters:
N, 8, number of request lines. The design is verified only at 8.
CW, 3, code width, equal to clog2(N).
ROUND_ROBIN, 0, arbitration mode. 0 = fixed priority, highest index wins (Y7 first). 1 = rotating priority starting after the last granted index.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous and active-low.
en  input  1  capture enable. While low, new edges are ignored and pending bits still drain.
y_in  input  N  request lines, synchronous to clk.
ready  input  1  consumer accepts the code this cycle.
clr_ovf  input  1  synchronous clear of overflow.
code  output  CW  encoded index of the granted line.
valid  output  1  code is valid.
pending  output  N  current pending vector.
pend_cnt  output  CW+1  popcount of pending.
overflow  output  1  sticky flag: an edge was lost.

Behaviour:
- Reset (async assert, sync release):
  - code=0, valid=0, pending=0, pend_cnt=0, overflow=0.
  - y_prev=0, rr_ptr=N-1, state=IDLE.
- Edge detect, every clock regardless of en:
  - y_prev <= y_in.
  - edge[i] = y_in[i] & ~y_prev[i] & en.
  - A line already high when en rises does not produce an edge.
- Pending update per bit: pending[i] <= (pending[i] & ~grant_clr[i]) | edge[i].
  - grant_clr[i] is set when index i is loaded into code this cycle.
  - Edge on bit i in the same cycle bit i is loaded: the bit stays set as a new event; no overflow.
- Overflow: set when edge[i] & pending[i] & ~grant_clr[i] for any i.
  - clr_ovf clears it.
  - Simultaneous set and clear: set wins.
- State machine:
  - IDLE: if pending != 0, pick an index, load code, set valid, clear that pending bit, go to VALID. Otherwise stay.
  - VALID: hold code and valid stable while ready=0.
  - VALID with ready=1 and pending (excluding the bit just granted) != 0: load the next pick in the same cycle, with no bubble, and stay in VALID.
  - VALID with ready=1 and pending == 0: valid <= 0, go to IDLE. code keeps its last value.
- Pick rules:
  - ROUND_ROBIN=0: highest set index.
  - ROUND_ROBIN=1: first set index searching upward from rr_ptr+1, wrapping mod N. rr_ptr <= granted index on each load.
  - Picks use pending as registered at the start of the cycle. An edge arriving in the same cycle is not eligible until the next cycle.
- Latency: y_in rises before edge k → pending set after edge k → valid high after edge k+1 (IDLE case). Throughput is one code per cycle while ready=1.
- pend_cnt is the registered popcount of the pending register, updated in the same cycle as pending.
- Mid-operation reset clears everything immediately. A code being offered is dropped.
- Multiple simultaneous edges all set pending in one cycle, then drain one per handshake.

Decomposition:
- Package enc_pkg: N, CW, state enum {IDLE, VALID}, and a popcount function.
- Sub-module pick_first (N, CW): combinational. Inputs: request vector and start index. Outputs: found flag and index. Rotates the request vector, does a priority search, and rotates the result back.
- Fixed-priority mode is pick_first on the bit-reversed request vector with start index 0, mapped back to the original index.
- Top level holds the registers and the FSM.

Test Plan:
- Reset mid-stream: pending=8'hA5, valid=1; pulse rst_n low → all outputs 0 asynchronously, before the next clk edge.
- en=1, y_in 8'h00 → 8'h04 with ready=1 → valid rises 2 edges later with code=3'd2, then deasserts; pend_cnt goes 0→1→0.
- Fixed priority: y_in 0→8'h91 in one cycle with ready=1 → pending=8'h91, pend_cnt=3, codes 7,4,0 on consecutive cycles, then valid=0.
- ROUND_ROBIN=1: repeat 8'h81 edges with ready=1 → codes 0,7,0,7 alternate.
- Backpressure: ready=0, line 3 edge while pending[3]=1 → overflow=1, code held stable; clr_ovf pulse → overflow=0.
- en=0 edge on y_in=8'h10 → no pending set. Raising en while line 4 is still high → no event. A new 0→1 transition on line 4 with en=1 → code=3'd4.
